pico16_timer: RTL and testbench

- Memory-mapped 16-bit down-counting timer peripheral on the PICO16a data bus.
- Sits between the CPU load/store port and the system interrupt/LED logic.
- The timer sample program programs it, polls or takes its interrupt, and reports the result through data memory.
- Provides a prescaler, one-shot or auto-reload mode, a sticky expiry flag and a level interrupt.

---
 rtl/pico16_timer_if.sv | 40 ++++
 rtl/pico16_timer.sv | 231 +++++++++++++++++++++++
 tb/tb_pico16_timer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pico16_timer_if.sv
// ---------------------------------------------------------------------------
// pico16_timer_if
//   Load/store bus between the PICO16a CPU data port and the timer peripheral.
//
//   addr   3      register select
//   wdata  WIDTH  write data
//   we     1      write strobe, one write per cycle it is high
//   re     1      read strobe
//   rdata  WIDTH  registered read data, returned the cycle after re
//
//   master : the CPU side, drives the request and receives rdata
//   slave  : the timer side, receives the request and drives rdata
// ---------------------------------------------------------------------------
interface pico16_timer_if #(
  parameter int WIDTH = 16
);

  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata
  );

endinterface : pico16_timer_if

// File: rtl/pico16_timer.sv
// ---------------------------------------------------------------------------
// pico16_timer
//   Memory-mapped down-counting timer with a prescaler, one-shot or
//   auto-reload operation, a sticky expiry flag and a level interrupt.
//
//   Ports
//     clk       system clock
//     reset     asynchronous, active-high reset
//     bus       slave side of the CPU load/store bus (addr/wdata/we/re/rdata)
//     irq       level interrupt, registered copy of EXP & IE
//     tick_out  high for the one cycle in which the prescaler rolls over
//
//   Register map
//     0 CTRL      [0] EN  [1] AR (auto-reload)  [2] IE, other bits read 0
//     1 PRESCALE  tick every PRESCALE+1 enabled cycles
//     2 RELOAD    value reloaded into COUNT on expiry when AR=1
//     3 COUNT     write loads the counter, read returns the live value
//     4 STATUS    [0] EXP, write 1 to clear
//     5..7        read as 0, writes ignored
// ---------------------------------------------------------------------------
module pico16_timer #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] PRESCALE_RST = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  pico16_timer_if.slave        bus,
  output logic                 irq,
  output logic                 tick_out
);

  // -------------------------------------------------------------------------
  // Register addresses
  // -------------------------------------------------------------------------
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_RELOAD   = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  // The EN bit of CTRL is the state of the timer: IDLE holds COUNT,
  // RUN lets prescaled ticks decrement it.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             ar;          // auto-reload
  logic             ie;          // interrupt enable
  logic             exp_flag;    // sticky expiry flag (STATUS[0])
  logic [WIDTH-1:0] prescale;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pcnt;        // prescale counter
  logic [WIDTH-1:0] read_mux;

  logic             wr_ctrl;
  logic             wr_prescale;
  logic             wr_reload;
  logic             wr_count;
  logic             wr_status;

  logic             tick;
  logic             expiry;
  logic             pcnt_clear;

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  assign wr_ctrl     = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_prescale = bus.we && (bus.addr == ADDR_PRESCALE);
  assign wr_reload   = bus.we && (bus.addr == ADDR_RELOAD);
  assign wr_count    = bus.we && (bus.addr == ADDR_COUNT);
  assign wr_status   = bus.we && (bus.addr == ADDR_STATUS);

  // -------------------------------------------------------------------------
  // State machine: next state and tick/expiry decode
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state lives in flops updated with <= so every always_ff sees the
    // values from before the edge, independent of block evaluation order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path through it can leave a signal unassigned and infer a latch.
    state_next = state;
    tick       = 1'b0;
    expiry     = 1'b0;

    case (state)
      IDLE: begin
        tick   = 1'b0;
        expiry = 1'b0;
      end
      RUN: begin
        tick   = (pcnt == prescale);
        // A tick that finds COUNT already at zero is the expiry; COUNT is
        // never decremented from zero.
        expiry = tick && (count == '0);
        if (expiry && !ar) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A CTRL write in the same cycle as a one-shot expiry decides EN.
    if (wr_ctrl) begin
      state_next = bus.wdata[0] ? RUN : IDLE;
    end
  end

  assign tick_out = tick;

  // -------------------------------------------------------------------------
  // Prescaler
  //   Held at 0 whenever the timer is (or is about to be) idle, which also
  //   covers the EN 0->1 restart. Rolls over on a tick and restarts on a
  //   COUNT write so the next tick is a full prescale period away. A PRESCALE
  //   write does not touch it: if the new limit is already behind pcnt, pcnt
  //   runs up to all-ones and wraps naturally.
  // -------------------------------------------------------------------------
  assign pcnt_clear = (state != RUN) || (state_next != RUN) || tick || wr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt_clear) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Software-visible registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here is a plain flop with a defined reset value;
    // there is no storage array, so nothing is left uninitialised.
    if (reset) begin
      ar       <= 1'b0;
      ie       <= 1'b0;
      prescale <= PRESCALE_RST;
      reload   <= '0;
    end else begin
      if (wr_ctrl) begin
        ar <= bus.wdata[1];
        ie <= bus.wdata[2];
      end
      if (wr_prescale) begin
        prescale <= bus.wdata;
      end
      if (wr_reload) begin
        reload <= bus.wdata;
      end
    end
  end

  // COUNT: a software write beats both the reload and the decrement.
  // On a one-shot expiry COUNT is already zero and simply stays there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.wdata;
    end else if (expiry) begin
      if (ar) begin
        count <= reload;
      end
    end else if (tick) begin
      count <= count - 1'b1;
    end
  end

  // EXP: hardware set beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_flag <= 1'b0;
    end else if (expiry) begin
      exp_flag <= 1'b1;
    end else if (wr_status && bus.wdata[0]) begin
      exp_flag <= 1'b0;
    end
  end

  // Registered level interrupt: follows EXP & IE one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= exp_flag && ie;
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  //   The mux looks at register values before the edge, so a read and write
  //   of the same address in one cycle returns the old contents.
  // -------------------------------------------------------------------------
  always_comb begin
    read_mux = '0;
    case (bus.addr)
      ADDR_CTRL:     read_mux = {{(WIDTH-3){1'b0}}, ie, ar, (state == RUN)};
      ADDR_PRESCALE: read_mux = prescale;
      ADDR_RELOAD:   read_mux = reload;
      ADDR_COUNT:    read_mux = count;
      ADDR_STATUS:   read_mux = {{(WIDTH-1){1'b0}}, exp_flag};
      default:       read_mux = '0;
    endcase
  end

  // rdata only changes on a read and holds its value in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rdata <= '0;
    end else if (bus.re) begin
      bus.rdata <= read_mux;
    end
  end

endmodule : pico16_timer

// File: tb/tb_pico16_timer.sv
// ---------------------------------------------------------------------------
// tb_pico16_timer
//   Self-checking bench for pico16_timer. Expected read data is queued when
//   the read is issued and popped when rdata returns one cycle later.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_pico16_timer;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_RELOAD   = 3'd2;
  localparam logic [2:0] A_COUNT    = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  logic tick_out;

  pico16_timer_if #(.WIDTH(16)) bus ();

  pico16_timer #(
    .WIDTH        (16),
    .PRESCALE_RST (16'h0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .irq      (irq),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  // -------------------------------------------------------------------------
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk); #1;
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk); #1;
    bus.re   = 1'b0;
    v        = bus.rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset;
    logic [15:0] got, want;
    reset     = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=0000", bus.rdata); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq); end
    n_cmp++;
    if (tick_out !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b want=0", tick_out); end
    idle(2);
    reset = 1'b0;
    idle(2);
    for (int a = 0; a < 5; a++) begin
      exp_q.push_back(16'h0000);
      rd(3'(a), got);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reset_reg%0d got=%h want=%h", a, got, want); end
    end
  endtask

  task automatic test_one_shot;
    logic [15:0] got, want;
    wr(A_PRESCALE, 16'd0);
    wr(A_COUNT,    16'd3);
    wr(A_CTRL,     16'h0001);            // enable edge E0
    // Read STATUS at E1..E6; EXP is set by the 4th tick (E4), visible from E5.
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back((k >= 5) ? 16'h0001 : 16'h0000);
      rd(A_STATUS, got);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL oneshot_exp_e%0d got=%h want=%h", k, got, want); end
    end
    exp_q.push_back(16'h0000);
    rd(A_COUNT, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL oneshot_count got=%h want=%h", got, want); end
    exp_q.push_back(16'h0000);
    rd(A_CTRL, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL oneshot_ctrl got=%h want=%h", got, want); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq got=%b want=0", irq); end
    wr(A_STATUS, 16'h0001);
  endtask

  task automatic test_auto_reload;
    logic [15:0] got, want;
    wr(A_PRESCALE, 16'd4);
    wr(A_RELOAD,   16'd2);
    wr(A_COUNT,    16'd2);
    wr(A_CTRL,     16'h0003);            // enable edge E0
    n_cmp++;
    if (tick_out !== 1'b0) begin n_err++; $display("FAIL ar_tick_e0 got=%b want=0", tick_out); end
    // Continuous COUNT read: sample after Ek shows COUNT as left by E(k-1).
    // Ticks land on E5, E10, ...; COUNT runs 2,1,0,2,1,0,...
    bus.addr = A_COUNT;
    bus.re   = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back(16'(2 - (((k - 1) / 5) % 3)));
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_cmp++;
      if (bus.rdata !== want) begin n_err++; $display("FAIL ar_count_e%0d got=%h want=%h", k, bus.rdata, want); end
      n_cmp++;
      if (tick_out !== (((k + 1) % 5) == 0)) begin
        n_err++; $display("FAIL ar_tick_e%0d got=%b want=%b", k, tick_out, (((k + 1) % 5) == 0));
      end
    end
    bus.re = 1'b0;
    exp_q.push_back(16'h0001);
    rd(A_STATUS, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL ar_status got=%h want=%h", got, want); end
    wr(A_CTRL,   16'h0000);
    wr(A_STATUS, 16'h0001);
  endtask

  task automatic test_irq;
    wr(A_PRESCALE, 16'd0);
    wr(A_COUNT,    16'd3);
    wr(A_CTRL,     16'h0005);            // enable edge E0, IE=1
    // EXP set at E4, irq follows at E5.
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (irq !== (k >= 5)) begin n_err++; $display("FAIL irq_rise_e%0d got=%b want=%b", k, irq, (k >= 5)); end
    end
    wr(A_STATUS, 16'h0000);              // no effect
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_w0_a got=%b want=1", irq); end
    idle(1);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_w0_b got=%b want=1", irq); end
    wr(A_STATUS, 16'h0001);              // clears EXP at this edge
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_w1_same got=%b want=1", irq); end
    idle(1);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1_next got=%b want=0", irq); end
    wr(A_CTRL, 16'h0000);
  endtask

  task automatic test_collision;
    logic [15:0] got, want;
    // Expiry and STATUS write-1-clear on the same edge: set wins.
    wr(A_STATUS, 16'h0001);
    wr(A_PRESCALE, 16'd0);
    wr(A_COUNT, 16'd3);
    wr(A_CTRL,  16'h0001);               // E0, expiry at E4
    idle(3);
    wr(A_STATUS, 16'h0001);              // lands on E4
    exp_q.push_back(16'h0001);
    rd(A_STATUS, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL coll_status got=%h want=%h", got, want); end

    // Expiry and COUNT write on the same edge: write wins, EXP still set.
    wr(A_STATUS, 16'h0001);
    wr(A_COUNT, 16'd3);
    wr(A_CTRL,  16'h0001);
    idle(3);
    wr(A_COUNT, 16'd9);                  // lands on E4
    exp_q.push_back(16'd9);
    rd(A_COUNT, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL coll_count got=%h want=%h", got, want); end
    exp_q.push_back(16'h0001);
    rd(A_STATUS, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL coll_count_exp got=%h want=%h", got, want); end
    exp_q.push_back(16'd9);
    rd(A_COUNT, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL coll_count_hold got=%h want=%h", got, want); end

    // One-shot expiry and CTRL write on the same edge: the written EN wins.
    wr(A_STATUS, 16'h0001);
    wr(A_COUNT, 16'd3);
    wr(A_CTRL,  16'h0001);
    idle(3);
    wr(A_CTRL,  16'h0001);               // lands on E4
    exp_q.push_back(16'h0001);
    rd(A_CTRL, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL coll_ctrl got=%h want=%h", got, want); end
    wr(A_CTRL,   16'h0000);
    wr(A_STATUS, 16'h0001);
  endtask

  task automatic test_bus;
    logic [15:0] got, want;
    wr(A_RELOAD, 16'hABCD);
    exp_q.push_back(16'hABCD);
    rd(A_RELOAD, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL bus_reload got=%h want=%h", got, want); end
    idle(2);
    n_cmp++;
    if (bus.rdata !== 16'hABCD) begin n_err++; $display("FAIL bus_hold got=%h want=abcd", bus.rdata); end
    wr(3'd6, 16'hFFFF);
    exp_q.push_back(16'h0000);
    rd(3'd6, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL bus_addr6 got=%h want=%h", got, want); end
    // Read and write RELOAD in the same cycle: old value returned.
    bus.addr  = A_RELOAD;
    bus.wdata = 16'h1234;
    bus.we    = 1'b1;
    bus.re    = 1'b1;
    exp_q.push_back(16'hABCD);
    @(posedge clk); #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
    want = exp_q.pop_front();
    n_cmp++;
    if (bus.rdata !== want) begin n_err++; $display("FAIL bus_rw_old got=%h want=%h", bus.rdata, want); end
    exp_q.push_back(16'h1234);
    rd(A_RELOAD, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL bus_rw_new got=%h want=%h", got, want); end
    wr(A_CTRL, 16'hFFFF);
    exp_q.push_back(16'h0007);
    rd(A_CTRL, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL bus_ctrl got=%h want=%h", got, want); end
    wr(A_CTRL,   16'h0000);
    wr(A_STATUS, 16'h0001);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  addrs[4] = '{A_PRESCALE, A_RELOAD, A_COUNT, 3'd5};
    logic [15:0] wants[4] = '{16'h0011, 16'h2222, 16'h0033, 16'h0000};
    wr(A_PRESCALE, 16'h0011);
    wr(A_RELOAD,   16'h2222);
    wr(A_COUNT,    16'h0033);
    bus.re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = addrs[i];
      exp_q.push_back(wants[i]);
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (bus.rdata !== exp_q[0]) begin
          n_err++; $display("FAIL b2b_rd%0d got=%h want=%h", i, bus.rdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    bus.re = 1'b0;
    wr(A_PRESCALE, 16'h0000);
  endtask

  task automatic test_reset_midrun;
    logic [15:0] got, want;
    wr(A_PRESCALE, 16'd3);
    wr(A_RELOAD,   16'd5);
    wr(A_COUNT,    16'd0);
    wr(A_CTRL,     16'h0007);            // E0; tick at E4 expires, irq at E5
    idle(5);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL mid_pre_irq got=%b want=1", irq); end
    wr(A_COUNT, 16'd7);
    exp_q.push_back(16'd5);
    rd(A_RELOAD, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL mid_pre_rd got=%h want=%h", got, want); end
    idle(2);
    #3;
    reset = 1'b1;                        // mid-cycle, no clock edge involved
    #1;
    n_cmp++;
    if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL mid_rdata got=%h want=0000", bus.rdata); end
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b want=0", irq); end
    n_cmp++;
    if (tick_out !== 1'b0) begin n_err++; $display("FAIL mid_tick got=%b want=0", tick_out); end
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    idle(2);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mid_post_irq got=%b want=0", irq); end
    n_cmp++;
    if (tick_out !== 1'b0) begin n_err++; $display("FAIL mid_post_tick got=%b want=0", tick_out); end
    for (int a = 0; a < 5; a++) begin
      exp_q.push_back(16'h0000);
      rd(3'(a), got);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL mid_reg%0d got=%h want=%h", a, got, want); end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequencer and watchdog
  // -------------------------------------------------------------------------
  initial begin
    test_reset;
    test_one_shot;
    test_auto_reload;
    test_irq;
    test_collision;
    test_bus;
    test_back_to_back;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pico16_timer
